// File: rtl/mz_pulse_sequencer.sv
// Trigger-driven RF pulse sequencer: plays Mach-Zehnder or Ramsey pulse trains
// with runtime durations, optional repeats, abort and status outputs.
module mz_pulse_sequencer #(
    parameter int CNT_W  = 32,
    parameter int SHOT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              abort,
    input  logic              mode,
    input  logic [CNT_W-1:0]  start_len,
    input  logic [CNT_W-1:0]  pi2_len,
    input  logic [CNT_W-1:0]  pi_len,
    input  logic [CNT_W-1:0]  wait_len,
    input  logic [CNT_W-1:0]  hold_len,
    input  logic [SHOT_W-1:0] shots,
    output logic              rf,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [2:0]        phase,
    output logic [SHOT_W-1:0] shot_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        P1    = 3'd2,
        W1    = 3'd3,
        P2    = 3'd4,
        W2    = 3'd5,
        P3    = 3'd6,
        HOLD  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SHOT_W-1:0] shot_q, shot_d;
    logic              rf_q, rf_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              s0_q, s1_q, s1d_q;
    logic              trig_edge;
    logic              accept;

    logic [CNT_W-1:0]  start_sh_q, pi2_sh_q, pi_sh_q, wait_sh_q, hold_sh_q;
    logic              mode_sh_q;
    logic [SHOT_W-1:0] shots_sh_q;

    logic [CNT_W-1:0]  len_cur;
    logic [CNT_W-1:0]  lim;
    logic              last;
    logic [SHOT_W-1:0] shots_eff;
    logic [SHOT_W:0]   shot_nxt;
    logic              more;

    assign trig_edge = s1_q & ~s1d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q  <= 1'b0;
            s1_q  <= 1'b0;
            s1d_q <= 1'b0;
        end else begin
            s0_q  <= trig;
            s1_q  <= s0_q;
            s1d_q <= s1_q;
        end
    end

    // Shadow copies of the run configuration, captured only on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            start_sh_q <= start_len;
            pi2_sh_q   <= pi2_len;
            pi_sh_q    <= pi_len;
            wait_sh_q  <= wait_len;
            hold_sh_q  <= hold_len;
            mode_sh_q  <= mode;
            shots_sh_q <= shots;
        end
    end

    always_comb begin
        len_cur = '0;
        case (state_q)
            START:   len_cur = start_sh_q;
            P1, P3:  len_cur = pi2_sh_q;
            W1, W2:  len_cur = wait_sh_q;
            P2:      len_cur = pi_sh_q;
            HOLD:    len_cur = hold_sh_q;
            default: len_cur = '0;
        endcase
        // A zero length dwells one cycle, same as a length of one.
        lim       = (len_cur == '0) ? '0 : len_cur - 1'b1;
        last      = (cnt_q == lim);
        shots_eff = (shots_sh_q == '0) ? SHOT_W'(1) : shots_sh_q;
        shot_nxt  = {1'b0, shot_q} + 1'b1;
        more      = (shot_nxt < {1'b0, shots_eff});
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        shot_d  = shot_q;
        done_d  = 1'b0;
        ovr_d   = 1'b0;
        accept  = 1'b0;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            shot_d  = '0;
        end else if (state_q == IDLE) begin
            cnt_d = '0;
            if (trig_edge) begin
                accept  = 1'b1;
                state_d = START;
                shot_d  = '0;
            end
        end else begin
            ovr_d = trig_edge;
            if (last) begin
                cnt_d = '0;
                case (state_q)
                    START:   state_d = P1;
                    P1:      state_d = W1;
                    W1:      state_d = mode_sh_q ? P3 : P2;
                    P2:      state_d = W2;
                    W2:      state_d = P3;
                    P3:      state_d = HOLD;
                    HOLD: begin
                        if (more) begin
                            state_d = START;
                            shot_d  = shot_nxt[SHOT_W-1:0];
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        rf_d = (state_d == P1) || (state_d == P2) || (state_d == P3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shot_q  <= '0;
            rf_q    <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shot_q  <= shot_d;
            rf_q    <= rf_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rf       = rf_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign overrun  = ovr_q;
    assign phase    = state_q;
    assign shot_idx = shot_q;

endmodule

// File: tb/tb_mz_pulse_sequencer.sv
// Scoreboard bench for mz_pulse_sequencer: each run pushes a cycle-by-cycle
// expected trace built from the configured durations, then compares it.
module tb_mz_pulse_sequencer;

    localparam int CNT_W  = 32;
    localparam int SHOT_W = 8;

    logic              clk = 1'b0;
    logic              rst, trig, abort, mode;
    logic [CNT_W-1:0]  start_len, pi2_len, pi_len, wait_len, hold_len;
    logic [SHOT_W-1:0] shots;
    logic              rf, busy, done, overrun;
    logic [2:0]        phase;
    logic [SHOT_W-1:0] shot_idx;

    mz_pulse_sequencer #(.CNT_W(CNT_W), .SHOT_W(SHOT_W)) dut (
        .clk(clk), .rst(rst), .trig(trig), .abort(abort), .mode(mode),
        .start_len(start_len), .pi2_len(pi2_len), .pi_len(pi_len),
        .wait_len(wait_len), .hold_len(hold_len), .shots(shots),
        .rf(rf), .busy(busy), .done(done), .overrun(overrun),
        .phase(phase), .shot_idx(shot_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]        ph;
        logic              rf;
        logic              busy;
        logic              done;
        logic              ov;
        logic [SHOT_W-1:0] shot;
        bit                chk_shot;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_e(input logic [2:0] ph, input logic r, input logic b,
                          input logic d, input int s, input bit cs);
        exp_t e;
        e.ph = ph; e.rf = r; e.busy = b; e.done = d; e.ov = 1'b0;
        e.shot = SHOT_W'(s); e.chk_shot = cs;
        q.push_back(e);
    endtask

    task automatic seg(input logic [2:0] ph, input int len, input logic r, input int s);
        int n;
        n = (len == 0) ? 1 : len;
        for (int c = 0; c < n; c++) push_e(ph, r, 1'b1, 1'b0, s, 1'b1);
    endtask

    // Drive the configuration and push the full expected trace, starting at
    // the first edge that samples the trigger high.
    task automatic cfg(input bit md, input int st, input int p2, input int pi,
                       input int w, input int h, input int sh);
        int ns;
        mode = md; start_len = st; pi2_len = p2; pi_len = pi;
        wait_len = w; hold_len = h; shots = SHOT_W'(sh);
        push_e(3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        push_e(3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        ns = (sh == 0) ? 1 : sh;
        for (int s = 0; s < ns; s++) begin
            seg(3'd1, st, 1'b0, s);
            seg(3'd2, p2, 1'b1, s);
            seg(3'd3, w,  1'b0, s);
            if (!md) begin
                seg(3'd4, pi, 1'b1, s);
                seg(3'd5, w,  1'b0, s);
            end
            seg(3'd6, p2, 1'b1, s);
            seg(3'd7, h,  1'b0, s);
        end
        push_e(3'd0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        push_e(3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Apply the trigger (plus optional extra trigger / abort / reset) and
    // compare the DUT against the queued trace one edge at a time.
    task automatic run(input int pulse2_at, input int kill_at, input bit kill_rst);
        exp_t e;
        int   i;
        if (kill_at >= 0) begin
            while (q.size() > kill_at) void'(q.pop_back());
            push_e(3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
            push_e(3'd0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        end
        if (pulse2_at >= 0) q[pulse2_at + 2].ov = 1'b1;
        i = 0;
        while (q.size() > 0) begin
            if (i == 0) trig = 1'b1;
            if (i == 3) trig = 1'b0;
            if (i == 5) begin
                mode = ~mode; start_len = 77; pi2_len = 2; pi_len = 0;
                wait_len = 1; hold_len = 99; shots = 8'd5;
            end
            if (i == pulse2_at) trig = 1'b1;
            if (pulse2_at >= 0 && i == pulse2_at + 3) trig = 1'b0;
            if (i == kill_at) begin
                if (kill_rst) rst = 1'b1; else abort = 1'b1;
            end
            if (kill_at >= 0 && i == kill_at + 1) begin
                rst = 1'b0; abort = 1'b0;
            end
            step();
            e = q.pop_front();
            check_eq($sformatf("phase@%0d", i), phase, e.ph);
            check_eq($sformatf("rf@%0d", i), rf, e.rf);
            check_eq($sformatf("busy@%0d", i), busy, e.busy);
            check_eq($sformatf("done@%0d", i), done, e.done);
            check_eq($sformatf("overrun@%0d", i), overrun, e.ov);
            if (e.chk_shot) check_eq($sformatf("shot_idx@%0d", i), shot_idx, e.shot);
            i++;
        end
        rst = 1'b0; abort = 1'b0; trig = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        // Trigger is held high through reset: exactly one run must follow.
        rst = 1'b1; trig = 1'b1; abort = 1'b0; mode = 1'b0;
        start_len = '0; pi2_len = '0; pi_len = '0; wait_len = '0; hold_len = '0;
        shots = '0;
        repeat (4) step();
        check_eq("rst_rf", rf, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_overrun", overrun, 1'b0);
        check_eq("rst_phase", phase, 3'd0);
        check_eq("rst_shot_idx", shot_idx, 8'd0);

        cfg(1'b0, 5, 3, 6, 10, 4, 1);
        rst = 1'b0;
        run(-1, -1, 1'b0);

        cfg(1'b1, 5, 3, 6, 10, 4, 1);
        run(-1, -1, 1'b0);

        cfg(1'b0, 5, 3, 6, 10, 4, 3);
        run(-1, -1, 1'b0);

        cfg(1'b0, 0, 0, 1, 0, 0, 0);
        run(-1, -1, 1'b0);

        cfg(1'b0, 5, 3, 6, 10, 4, 1);
        run(12, -1, 1'b0);

        cfg(1'b0, 5, 3, 6, 10, 4, 1);
        run(-1, 22, 1'b0);
        cfg(1'b0, 5, 3, 6, 10, 4, 1);
        run(-1, -1, 1'b0);

        cfg(1'b0, 5, 3, 6, 10, 4, 1);
        run(-1, 37, 1'b1);
        cfg(1'b0, 5, 3, 6, 10, 4, 1);
        run(-1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mz_pulse_sequencer.md
Name: mz_pulse_sequencer

Overview:
- Trigger-driven RF pulse sequencer for the atom-interferometry control path. Drives the RF controller gate line `rf`.
- On a synchronised rising edge of `trig`, plays one of two sequences, then optionally repeats it N times:
  - Mach-Zehnder (MZ): pi/2 - T - pi - T - pi/2
  - Ramsey: pi/2 - T - pi/2
- All durations are runtime inputs, latched per trigger, in clock cycles.
- Successor to the fixed-timing controller. Adds mode select, repeat count, abort, and status outputs.

Parameters:
- CNT_W, 32, width of every duration input and of the internal cycle counter.
- SHOT_W, 8, width of the repeat-count input and the shot counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- trig  in  1  asynchronous trigger from the Arduino. Rising edge starts a run.
- abort  in  1  synchronous. Forces an immediate return to IDLE.
- mode  in  1  0 = MZ, 1 = Ramsey.
- start_len  in  CNT_W  dead time between trigger and first pulse.
- pi2_len  in  CNT_W  pi/2 pulse length.
- pi_len  in  CNT_W  pi pulse length (used in MZ mode only).
- wait_len  in  CNT_W  free-evolution interval T.
- hold_len  in  CNT_W  post-sequence holdoff.
- shots  in  SHOT_W  sequences per trigger. 0 is treated as 1.
- rf  out  1  RF gate, registered.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- overrun  out  1  one-cycle pulse when a trigger edge arrives while busy.
- phase  out  3  current state encoding.
- shot_idx  out  SHOT_W  index of the current shot, 0-based.

Behaviour:
- Reset values: rf=0, busy=0, done=0, overrun=0, phase=IDLE, shot_idx=0.
  - Cycle counter, shot counter and sync flops all reset to 0.
  - rst overrides abort and trig.
- Trigger synchroniser:
  - 2-flop synchroniser s0 -> s1, then edge register s1_d.
  - trig_edge = s1 & ~s1_d.
  - If trig is sampled high at clock edge k, the state leaves IDLE at edge k+2.
  - trig held high through reset produces exactly one edge after release.
- State encodings: IDLE=0, START=1, P1=2, W1=3, P2=4, W2=5, P3=6, HOLD=7.
- Trigger acceptance (IDLE with trig_edge):
  - Latch all *_len inputs, mode and shots into shadow registers.
  - Clear the counter and shot_idx, then enter START.
  - Inputs changing mid-run have no effect.
- Dwell rule:
  - Each non-IDLE state lasts exactly max(len,1) cycles of its latched length.
  - The counter counts from 0 and advances the state when counter == max(len,1)-1. It clears on every transition.
- Transition sequence:
  - MZ: START -> P1 -> W1 -> P2 -> W2 -> P3 -> HOLD.
  - Ramsey: START -> P1 -> W1 -> P3 -> HOLD.
- End of HOLD:
  - If shot_idx+1 < max(shots,1): shot_idx increments and the state goes to START with no new trigger needed.
  - Otherwise: state goes to IDLE and done pulses in the cycle IDLE is entered.
- rf is registered from next-state. It is 1 exactly during P1, P2 and P3, so rf and phase change on the same edge.
- abort:
  - When sampled high in any state, next edge: state=IDLE, rf=0, shot_idx=0.
  - No done pulse. A trig_edge in that same cycle is ignored.
- Trigger while busy:
  - A trig_edge in any non-IDLE state is dropped and overrun pulses one cycle. Nothing is queued.
  - A trig_edge on the exact cycle the state returns to IDLE is also dropped, with an overrun pulse.
  - A trig_edge in the first IDLE cycle is accepted.
- Widths: a counter of CNT_W bits never wraps, because the compare fires before all-ones.
- Maximum dwell is 2^CNT_W - 1 cycles.

Test Plan:
- Basic MZ timing: mode=0, start=5, pi2=3, pi=6, wait=10, hold=4, shots=1; trig rises before edge k.
  - busy rises at edge k+2.
  - rf is high over [k+7,k+10), [k+20,k+26) and [k+36,k+39).
  - done pulses at edge k+43; busy falls at the same edge.
- Ramsey mode, same lengths, mode=1: rf is high over [k+7,k+10) and [k+20,k+23). done pulses at k+27. phase never shows 4 or 5.
- Repeat: shots=3, MZ lengths as above.
  - Three identical rf patterns, each 41 cycles apart.
  - shot_idx steps 0, 1, 2.
  - A single done pulse follows the third HOLD.
- Zero and minimum lengths: pi2=0, wait=0, start=0, pi=1, hold=0. Every state lasts 1 cycle, and rf reads 1,0,1,0,1 across P1..P3.
- Abort and overrun:
  - A second trig edge during W1 -> one overrun pulse, and the sequence is unaffected.
  - abort asserted during P2 -> rf=0 and phase=0 on the next edge, with no done pulse.
  - A fresh trig afterwards starts a full, correct run.
- Reset mid-run: rst asserted during P3 for 1 cycle -> all outputs at reset values on the next edge, and the cycle counter reads 0 on the next run.
